uart_tx_drain: RTL and testbench

- Downstream consumer of the byte FIFO's read port.
- Pops 8-bit words over a ready/valid handshake and serialises each one as an asynchronous UART frame: start bit, 8 data bits LSB-first, optional parity, stop bit(s).
- Sits between the FIFO and the chip's TX pin. Its ready provides FIFO backpressure for the whole frame duration.

---
 rtl/uart_tx_drain_if.sv | 18 +
 rtl/uart_tx_drain.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_drain.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_drain_if.sv
// Read-side handshake between the byte FIFO (master) and the UART transmitter (slave).
interface uart_tx_drain_if;
  logic       read_valid;
  logic [7:0] read_data;
  logic       read_ready;

  modport master (
    output read_valid,
    output read_data,
    input  read_ready
  );

  modport slave (
    input  read_valid,
    input  read_data,
    output read_ready
  );
endinterface

// File: rtl/uart_tx_drain.sv
// FIFO-draining UART transmitter: start bit, 8 data bits LSB first, optional even parity
// (enabled by defining UART_TX_DRAIN_PARITY_EN), then STOP_BITS stop bits.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic             i_clock,
  input  logic             i_nreset,
  uart_tx_drain_if.slave   rd,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state_r, state_n;
  logic [CNT_W-1:0] baud_r, baud_n;
  logic [2:0]       bit_r, bit_n;
  logic [7:0]       shift_r, shift_n;
  logic             ready_r, busy_r, done_r, tx_r;
  logic             busy_n, done_n;
  logic             take_s, bit_end_s, par_bit_s;

  // Line level for a given state; the line lags the state register by one cycle.
  function automatic logic tx_level(input logic [2:0] st, input logic lsb, input logic par);
    logic lvl;
    case (st)
      S_IDLE:   lvl = 1'b1;
      S_START:  lvl = 1'b0;
      S_DATA:   lvl = lsb;
      S_PARITY: lvl = par;
      S_STOP:   lvl = 1'b1;
      default:  lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  assign bit_end_s = (baud_r == BAUD_LAST);

`ifdef UART_TX_DRAIN_PARITY_EN
  logic parity_r;

  function automatic logic calc_parity(input logic [7:0] d);
    return ^d;
  endfunction

  // Even parity bit captured together with the byte.
  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) begin
      parity_r <= 1'b0;
    end else if (take_s) begin
      parity_r <= calc_parity(rd.read_data);
    end else begin
      parity_r <= parity_r;
    end
  end

  assign par_bit_s = parity_r;
`else
  assign par_bit_s = 1'b1;
`endif

  // Frame sequencing: next state, baud/bit counters and shift register.
  always_comb begin
    state_n = state_r;
    baud_n  = baud_r;
    bit_n   = bit_r;
    shift_n = shift_r;
    take_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rd.read_valid && ready_r) begin
          take_s  = 1'b1;
          state_n = S_START;
          baud_n  = {CNT_W{1'b0}};
          bit_n   = 3'd0;
          shift_n = rd.read_data;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_n = S_DATA;
          baud_n  = {CNT_W{1'b0}};
          bit_n   = 3'd0;
        end else begin
          baud_n = baud_r + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          baud_n  = {CNT_W{1'b0}};
          shift_n = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
`ifdef UART_TX_DRAIN_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
            bit_n = 3'd0;
          end else begin
            bit_n = bit_r + 3'd1;
          end
        end else begin
          baud_n = baud_r + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_n = S_STOP;
          baud_n  = {CNT_W{1'b0}};
          bit_n   = 3'd0;
        end else begin
          baud_n = baud_r + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          baud_n = {CNT_W{1'b0}};
          if (bit_r == STOP_LAST) begin
            state_n = S_IDLE;
            bit_n   = 3'd0;
          end else begin
            bit_n = bit_r + 3'd1;
          end
        end else begin
          baud_n = baud_r + CNT_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = {CNT_W{1'b0}};
        bit_n   = 3'd0;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with state_r.
  always_comb begin
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_STOP) && (baud_n == BAUD_LAST) && (bit_n == STOP_LAST);
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) begin
      state_r <= S_IDLE;
      baud_r  <= {CNT_W{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_n;
      baud_r  <= baud_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
      ready_r <= (state_n == S_IDLE);
      busy_r  <= busy_n;
      done_r  <= done_n;
      tx_r    <= tx_level(state_r, shift_r[0], par_bit_s);
    end
  end

  assign rd.read_ready = ready_r;
  assign o_tx          = tx_r;
  assign o_busy        = busy_r;
  assign o_frame_done  = done_r;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: one-stop-bit and two-stop-bit instances fed from queue FIFOs.
module tb_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_DRAIN_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int TR = 4096;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  uart_tx_drain_if if_a();
  uart_tx_drain_if if_b();

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .i_clock(clk), .i_nreset(rst_a), .rd(if_a),
    .o_tx(tx_a), .o_busy(busy_a), .o_frame_done(done_a)
  );

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .i_clock(clk), .i_nreset(rst_b), .rd(if_b),
    .o_tx(tx_b), .o_busy(busy_b), .o_frame_done(done_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int acc_a[$];
  int acc_b[$];
  logic [7:0] pop_tmp;
  logic tx_tr   [0:1][0:TR-1];
  logic busy_tr [0:1][0:TR-1];
  logic done_tr [0:1][0:TR-1];
  logic rdy_tr  [0:1][0:TR-1];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge counter and FIFO pops; handshake sampled with pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (if_a.read_valid && if_a.read_ready) begin
      acc_a.push_back(cyc);
      pop_tmp = q_a.pop_front();
    end
    if (if_b.read_valid && if_b.read_ready) begin
      acc_b.push_back(cyc);
      pop_tmp = q_b.pop_front();
    end
  end

  // Trace capture and FIFO head drive, away from the active edge.
  always @(negedge clk) begin
    if (cyc < TR) begin
      tx_tr[0][cyc] = tx_a;   busy_tr[0][cyc] = busy_a;
      done_tr[0][cyc] = done_a; rdy_tr[0][cyc] = if_a.read_ready;
      tx_tr[1][cyc] = tx_b;   busy_tr[1][cyc] = busy_b;
      done_tr[1][cyc] = done_b; rdy_tr[1][cyc] = if_b.read_ready;
    end
    if_a.read_valid = (q_a.size() > 0);
    if_a.read_data  = (q_a.size() > 0) ? q_a[0] : 8'h00;
    if_b.read_valid = (q_b.size() > 0);
    if_b.read_data  = (q_b.size() > 0) ? q_b[0] : 8'h00;
  end

  task automatic wait_accept(input int sel, output int a);
    int n = 0;
    while (((sel == 0) ? acc_a.size() : acc_b.size()) == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (((sel == 0) ? acc_a.size() : acc_b.size()) == 0) begin
      check_value($sformatf("dut%0d_accept_timeout", sel), 32'd0, 32'd1);
      a = -1;
    end else if (sel == 0) begin
      a = acc_a.pop_front();
    end else begin
      a = acc_b.pop_front();
    end
  endtask

  function automatic int frame_len(input int stop_bits);
    return (9 + PAR_BITS + stop_bits) * CPB;
  endfunction

  // Checks one frame whose accepting edge was edge number a.
  task automatic check_frame(input int sel, input int a, input logic [7:0] d, input int stop_bits);
    int nb, f, cnt_busy, cnt_done, cnt_rdy, done_pos;
    logic [11:0] fb;
    logic [3:0]  obs;
    logic [7:0]  dec;
    if (a >= 1) begin
      nb = 9 + PAR_BITS + stop_bits;
      f  = nb * CPB;
      fb = 12'hFFF;
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[1+i] = d[i];
      if (PAR_BITS == 1) fb[9] = ^d;
      while (cyc < a + f + 2) @(negedge clk);
      check_value($sformatf("dut%0d_%02h_idle_before_start", sel, d), 32'(tx_tr[sel][a]), 32'd1);
      for (int b = 0; b < nb; b++) begin
        for (int j = 0; j < CPB; j++) obs[j] = tx_tr[sel][a + 1 + CPB*b + j];
        check_value($sformatf("dut%0d_%02h_bit%0d", sel, d, b), 32'(obs), fb[b] ? 32'hF : 32'h0);
      end
      for (int i = 0; i < 8; i++) dec[i] = tx_tr[sel][a + 1 + CPB*(i+1) + 2];
      check_value($sformatf("dut%0d_%02h_decode", sel, d), 32'(dec), 32'(d));
      cnt_busy = 0; cnt_done = 0; cnt_rdy = 0; done_pos = -1;
      for (int i = a - 1; i <= a + f; i++) begin
        if (busy_tr[sel][i]) cnt_busy++;
        if (done_tr[sel][i]) begin cnt_done++; done_pos = i - a; end
      end
      for (int i = a; i < a + f; i++) if (rdy_tr[sel][i]) cnt_rdy++;
      check_value($sformatf("dut%0d_%02h_busy_cycles", sel, d), 32'(cnt_busy), 32'(f));
      check_value($sformatf("dut%0d_%02h_done_count", sel, d), 32'(cnt_done), 32'd1);
      check_value($sformatf("dut%0d_%02h_done_pos", sel, d), 32'(done_pos), 32'(f - 1));
      check_value($sformatf("dut%0d_%02h_ready_in_frame", sel, d), 32'(cnt_rdy), 32'd0);
      check_value($sformatf("dut%0d_%02h_ready_after", sel, d), 32'(rdy_tr[sel][a + f]), 32'd1);
    end
  endtask

  initial begin
    int s, a, a1, a2, a3, cnt_tx, cnt_busy, cnt_rdy;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_tx", 32'(tx_a), 32'd1);
    check_value("rst_busy", 32'(busy_a), 32'd0);
    check_value("rst_ready", 32'(if_a.read_ready), 32'd0);
    check_value("rst_done", 32'(done_a), 32'd0);
    check_value("rst_tx_b", 32'(tx_b), 32'd1);

    // 1: idle with an empty FIFO
    rst_a = 1'b1;
    rst_b = 1'b1;
    s = cyc;
    repeat (21) @(negedge clk);
    cnt_tx = 0; cnt_busy = 0; cnt_rdy = 0;
    for (int i = s + 1; i <= s + 20; i++) begin
      if (tx_tr[0][i]) cnt_tx++;
      if (busy_tr[0][i]) cnt_busy++;
      if (rdy_tr[0][i]) cnt_rdy++;
    end
    check_value("idle_tx_high", 32'(cnt_tx), 32'd20);
    check_value("idle_busy_low", 32'(cnt_busy), 32'd0);
    check_value("idle_ready_high", 32'(cnt_rdy), 32'd20);
    check_value("idle_no_pops", 32'(acc_a.size()), 32'd0);

    // 2: single byte A5
    q_a.push_back(8'hA5);
    s = cyc;
    wait_accept(0, a);
    check_value("a5_accept_edge", 32'(a), 32'(s + 1));
    check_frame(0, a, 8'hA5, 1);

    // 3: three queued bytes back to back
    q_a.push_back(8'h01);
    q_a.push_back(8'h02);
    q_a.push_back(8'h03);
    s = cyc;
    wait_accept(0, a1);
    check_value("b2b_first_accept", 32'(a1), 32'(s + 1));
    check_frame(0, a1, 8'h01, 1);
    wait_accept(0, a2);
    check_value("b2b_gap_1_2", 32'(a2 - a1), 32'(frame_len(1) + 1));
    check_frame(0, a2, 8'h02, 1);
    wait_accept(0, a3);
    check_value("b2b_gap_2_3", 32'(a3 - a2), 32'(frame_len(1) + 1));
    check_frame(0, a3, 8'h03, 1);
    check_value("b2b_fifo_empty", 32'(q_a.size()), 32'd0);

    // 4: two stop bits, byte 00
    q_b.push_back(8'h00);
    wait_accept(1, a);
    check_frame(1, a, 8'h00, 2);

    // 5: reset during data bit 3 of FF, then a clean 55 frame
    q_a.push_back(8'hFF);
    wait_accept(0, a);
    if (a >= 1) begin
      while (cyc < a + 18) @(negedge clk);
      check_value("rst_mid_busy_before", 32'(busy_a), 32'd1);
      #2;
      rst_a = 1'b0;
      #1;
      check_value("rst_mid_tx", 32'(tx_a), 32'd1);
      check_value("rst_mid_busy", 32'(busy_a), 32'd0);
      check_value("rst_mid_ready", 32'(if_a.read_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      check_value("rst_mid_stale_accepts", 32'(acc_a.size()), 32'd0);
      q_a.push_back(8'h55);
      s = cyc;
      wait_accept(0, a);
      check_value("rst_mid_55_accept", 32'(a), 32'(s + 2));
      check_frame(0, a, 8'h55, 1);
    end

`ifdef UART_TX_DRAIN_PARITY_EN
    // 6: parity frames
    q_a.push_back(8'hA5);
    wait_accept(0, a);
    check_frame(0, a, 8'hA5, 1);
    if (a >= 1) check_value("par_a5_bit", 32'(tx_tr[0][a + 1 + CPB*9 + 1]), 32'd0);
    q_a.push_back(8'h07);
    wait_accept(0, a);
    check_frame(0, a, 8'h07, 1);
    if (a >= 1) check_value("par_07_bit", 32'(tx_tr[0][a + 1 + CPB*9 + 1]), 32'd1);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
